// File: rtl/aes_word_loader.sv
// Word-stream front end for aes_128: loads key and block, starts the core,
// streams the result back. Build option: KEY_REUSE_EN (keep key via key_hold).
// Ports: clk, rst (async, active-high); s_valid/s_ready/s_data input stream;
// key_hold; aes_start/aes_state/aes_key to core; aes_done/aes_out from core;
// m_valid/m_ready/m_data output stream; busy job-in-flight flag.
module aes_word_loader #(
  parameter int WORD_SIZE    = 32,
  parameter int BLOCK_LENGTH = 128,
  parameter int KEY_SIZE     = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WORD_SIZE-1:0]    s_data,
  input  logic                    key_hold,
  output logic                    aes_start,
  output logic [BLOCK_LENGTH-1:0] aes_state,
  output logic [KEY_SIZE-1:0]     aes_key,
  input  logic                    aes_done,
  input  logic [BLOCK_LENGTH-1:0] aes_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WORD_SIZE-1:0]    m_data,
  output logic                    busy
);

  localparam int NW = BLOCK_LENGTH / WORD_SIZE;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam int BW = BLOCK_LENGTH;
  localparam int W  = WORD_SIZE;

  typedef enum logic [2:0] {
    ST_KEY,
    ST_DATA,
    ST_START,
    ST_BUSY,
    ST_OUT
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            key_loaded;
  logic [BW-1:0]   res;
  logic            s_fire;
  logic            m_fire;
  logic            last;
  logic            reuse;

  assign s_fire = s_valid & s_ready;
  assign m_fire = m_valid & m_ready;
  assign last   = (cnt == CW'(NW - 1));

`ifdef KEY_REUSE_EN
  assign reuse = key_hold & key_loaded;
`else
  logic unused_ok;
  assign reuse     = 1'b0;
  assign unused_ok = key_hold ^ key_loaded;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_KEY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    s_ready   = 1'b0;
    aes_start = 1'b0;
    m_valid   = 1'b0;
    unique case (state)
      ST_KEY: begin
        s_ready = 1'b1;
        if (s_valid && last) state_nx = ST_DATA;
      end
      ST_DATA: begin
        s_ready = 1'b1;
        if (s_valid && last) state_nx = ST_START;
      end
      ST_START: begin
        aes_start = 1'b1;
        state_nx  = ST_BUSY;
      end
      ST_BUSY: begin
        if (aes_done) state_nx = ST_OUT;
      end
      ST_OUT: begin
        m_valid = 1'b1;
        if (m_ready && last)
          state_nx = reuse ? ST_DATA : ST_KEY;
      end
      default: state_nx = ST_KEY;
    endcase
  end

  // Words arrive MSB-first, so shifting in from the bottom lands each
  // word in its slot; the result is shifted out from the top likewise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      key_loaded <= 1'b0;
      aes_key    <= '0;
      aes_state  <= '0;
      res        <= '0;
      m_data     <= '0;
      busy       <= 1'b0;
    end else begin
      if (s_fire || m_fire) cnt <= cnt + CW'(1);
      if (s_fire) busy <= 1'b1;
      if (s_fire && state == ST_KEY) begin
        aes_key <= {aes_key[KEY_SIZE-W-1:0], s_data};
        if (last) key_loaded <= 1'b1;
      end
      if (s_fire && state == ST_DATA)
        aes_state <= {aes_state[BW-W-1:0], s_data};
      if (state == ST_BUSY && aes_done) begin
        res    <= aes_out;
        m_data <= aes_out[BW-1 -: W];
      end
      if (m_fire) begin
        res    <= {res[BW-W-1:0], {W{1'b0}}};
        m_data <= res[BW-W-1 -: W];
        if (last) busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_word_loader.sv
// Randomized scoreboard bench for aes_word_loader with a stand-in core.
// Optional KEY_REUSE_EN changes the expected key-reuse behaviour.
module tb_aes_word_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         key_hold = 1'b0;
  logic         aes_start;
  logic [127:0] aes_state;
  logic [127:0] aes_key;
  logic         aes_done = 1'b0;
  logic [127:0] aes_out = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [31:0]  m_data;
  logic         busy;

  aes_word_loader dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .key_hold(key_hold),
    .aes_start(aes_start), .aes_state(aes_state), .aes_key(aes_key),
    .aes_done(aes_done), .aes_out(aes_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  // Stand-in cipher: the FIPS-197 C.1 vector, otherwise a fixed mix.
  function automatic logic [127:0] core_fn(input logic [127:0] k,
                                           input logic [127:0] p);
    if (k == FK && p == FP) return FC;
    return {p[95:0], p[127:96]} ^ k ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_1234_5678;
  endfunction

  function automatic logic [31:0] wd(input logic [127:0] b, input int i);
    return b[127 - 32*i -: 32];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [31:0]  exp_q[$];
  logic [127:0] kq[$];
  logic [127:0] sq[$];

  // core model
  int           core_lat = 4;
  int           ccnt = 0;
  bit           spur_req = 0;
  bit           core_real = 0;
  logic [127:0] ck = '0;
  logic [127:0] cp = '0;

  always @(posedge clk) begin
    #2;
    aes_done  = 1'b0;
    aes_out   = rnd128();
    core_real = 0;
    if (rst) begin
      ccnt     = 0;
      spur_req = 0;
    end else begin
      if (spur_req) begin
        aes_done = 1'b1;
        aes_out  = '1;
        spur_req = 0;
      end else if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) begin
          aes_done  = 1'b1;
          core_real = 1;
          aes_out   = core_fn(ck, cp);
        end
      end
      if (aes_start) begin
        ck   = aes_key;
        cp   = aes_state;
        ccnt = core_lat;
      end
    end
  end

  // downstream ready driver
  int bp_left = 0;
  bit bp_arm = 0;

  always @(posedge clk) begin
    #2;
    if (bp_left > 0) begin
      m_ready = 1'b0;
      bp_left--;
    end else if (bp_arm && m_valid) begin
      bp_arm  = 0;
      bp_left = 4;
      m_ready = 1'b0;
    end else begin
      m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor / scoreboard
  bit          act = 0;
  int          outn = 0;
  bit          prev_start = 0;
  bit          done_prev = 0;
  bit          stall = 0;
  logic [31:0] stall_d = '0;

  always @(negedge clk) begin
    if (rst) begin
      act = 0; outn = 0; prev_start = 0;
      done_prev = 0; stall = 0;
    end else begin
      if (aes_start) begin
        chk("start_one_cycle", prev_start, 0);
        chk("busy_at_start", busy, 1);
        if (kq.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          chk("aes_key", aes_key, kq.pop_front());
          chk("aes_state", aes_state, sq.pop_front());
        end
        act = 1;
        outn = 0;
      end
      prev_start = aes_start;
      if (act) chk("s_ready_low_in_job", s_ready, 0);
      else     chk("m_valid_idle", m_valid, 0);
      if (done_prev) chk("done_to_valid", m_valid, 1);
      done_prev = aes_done && core_real;
      if (aes_done && core_real) begin
        chk("key_stable", aes_key, ck);
        chk("state_stable", aes_state, cp);
      end
      if (stall) begin
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, stall_d);
      end
      stall = m_valid && !m_ready;
      stall_d = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", m_data, 0);
        else chk("m_data", m_data, exp_q.pop_front());
        outn++;
        if (outn == 4) act = 0;
      end
    end
  end

  // stimulus helpers (called at a negedge)
  task automatic send_w(input logic [31:0] w, input bit bub);
    int n;
    n = 0;
    if (bub) repeat ($urandom_range(0, 3)) @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("s_ready_timeout", 0, 1);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic expect_job(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] r;
    r = core_fn(k, p);
    kq.push_back(k);
    sq.push_back(p);
    for (int i = 0; i < 4; i++) exp_q.push_back(wd(r, i));
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] p,
                      input bit with_key, input bit bub, input bit spur);
    expect_job(k, p);
    if (spur) begin
      spur_req = 1;
      repeat (3) @(negedge clk);
    end
    if (with_key)
      for (int i = 0; i < 4; i++) send_w(wd(k, i), bub);
    for (int i = 0; i < 4; i++) begin
      send_w(wd(p, i), bub);
      if (spur && i == 1) begin
        spur_req = 1;
        repeat (3) @(negedge clk);
      end
    end
    chk("start_at_T+1", aes_start, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() > 0 || act) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_aes_start", aes_start, 0);
    chk("rst_aes_state", aes_state, 0);
    chk("rst_aes_key", aes_key, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1 chk("s_ready_after_rst", s_ready, 1);
    @(negedge clk);

    // FIPS-197 C.1 vector
    load(FK, FP, 1, 0, 0);
    drain();

    // backpressure on the first output word
    bp_arm = 1;
    load(FK, FP, 1, 0, 0);
    drain();

    // random jobs with input bubbles and varied core latency
    load(FK, FP, 1, 1, 0);
    drain();
    for (int j = 0; j < 6; j++) begin
      core_lat = $urandom_range(1, 8);
      load(rnd128(), rnd128(), 1, 1, 0);
      drain();
    end

    // spurious done in key and data phases
    core_lat = 3;
    load(rnd128(), rnd128(), 1, 0, 1);
    drain();

    // reset while the core is busy
    core_lat = 30;
    load(rnd128(), rnd128(), 1, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_aes_start", aes_start, 0);
    chk("mid_rst_aes_state", aes_state, 0);
    chk("mid_rst_aes_key", aes_key, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    kq.delete();
    sq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("s_ready_after_mid_rst", s_ready, 1);
    @(negedge clk);
    core_lat = 5;
    load(FK, FP, 1, 1, 0);
    drain();

    // key_hold on the final output handshake
    key_hold = 1'b1;
    load(FK, FP, 1, 0, 0);
    drain();
    key_hold = 1'b0;
`ifdef KEY_REUSE_EN
    load(FK, FP, 0, 0, 0);
    drain();
`else
    expect_job(FP, FP);
    for (int i = 0; i < 4; i++) send_w(wd(FP, i), 0);
    chk("no_start_after_4", aes_start, 0);
    for (int i = 0; i < 4; i++) send_w(wd(FP, i), 0);
    chk("start_after_8", aes_start, 1);
    drain();
`endif

    load(rnd128(), rnd128(), 1, 1, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
